fetch_unit_v1: RTL and testbench

Instruction fetch stage of the RISC-V core: holds the PC, issues one request at a time to instruction memory over a req/ack handshake, and presents the fetched word to decode over a valid/ready handshake. The next PC is chosen by a 4-input next-PC mux. Its select comes from the redirect port of later stages or defaults to sequential. One outstanding memory request and one buffered instruction at most.

---
 rtl/core_pkg.sv | 16 +
 rtl/mux4_v1.sv | 24 ++
 rtl/fetch_unit_v1.sv | 121 ++++++++++++
 tb/tb_fetch_unit_v1.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state encoding and next-PC mux select codes.
package core_pkg;

   typedef enum logic [1:0] {
      START = 2'b00,
      FETCH = 2'b01,
      VALID = 2'b10,
      DRAIN = 2'b11
   } fetch_state_t;

   localparam logic [1:0] NPC_SEQ    = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_TRAP   = 2'b11;

endpackage

// File: rtl/mux4_v1.sv
// Generic 4-input combinational multiplexer, used for next-PC selection.
module mux4_v1 #(
   parameter int width = 32
) (
   input  logic [width-1:0] d0,
   input  logic [width-1:0] d1,
   input  logic [width-1:0] d2,
   input  logic [width-1:0] d3,
   input  logic [1:0]       sel,
   output logic [width-1:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         2'b00:   y = d0;
         2'b01:   y = d1;
         2'b10:   y = d2;
         2'b11:   y = d3;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/fetch_unit_v1.sv
// Instruction fetch stage: PC register, single-outstanding imem request,
// one-entry instruction buffer towards decode, redirect handling.
module fetch_unit_v1
   import core_pkg::*;
#(
   parameter int               width        = 32,
   parameter logic [width-1:0] reset_vector = '0,
   parameter logic [width-1:0] trap_vector  = width'(32'h0000_0100)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [width-1:0] imem_addr,
   input  logic [width-1:0] imem_rdata,
   input  logic             imem_ack,
   output logic             fetch_valid,
   output logic [width-1:0] fetch_pc,
   output logic [width-1:0] fetch_instr,
   input  logic             decode_ready,
   input  logic             redirect_valid,
   input  logic [1:0]       redirect_sel,
   input  logic [width-1:0] branch_target,
   input  logic [width-1:0] jump_target
);

   fetch_state_t     state_reg, state_next;
   logic [width-1:0] pc_reg, pc_next;
   logic [width-1:0] addr_reg, addr_next;
   logic [width-1:0] fpc_reg, fpc_next;
   logic [width-1:0] finstr_reg, finstr_next;

   logic [1:0]       npc_sel;
   logic [width-1:0] npc_raw;
   logic [width-1:0] npc;

   assign npc_sel = redirect_valid ? redirect_sel : NPC_SEQ;

   mux4_v1 #(
      .width(width)
   ) u_npc_mux (
      .d0  (pc_reg + width'(4)),
      .d1  (branch_target),
      .d2  (jump_target),
      .d3  (trap_vector),
      .sel (npc_sel),
      .y   (npc_raw)
   );

   // Instruction addresses are always word aligned.
   assign npc = {npc_raw[width-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= START;
         pc_reg     <= reset_vector;
         addr_reg   <= reset_vector;
         fpc_reg    <= '0;
         finstr_reg <= '0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         addr_reg   <= addr_next;
         fpc_reg    <= fpc_next;
         finstr_reg <= finstr_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      addr_next   = addr_reg;
      fpc_next    = fpc_reg;
      finstr_next = finstr_reg;
      case (state_reg)
         START: begin
            addr_next  = pc_reg;
            state_next = FETCH;
         end
         FETCH: begin
            if (redirect_valid) begin
               pc_next = npc;
               if (imem_ack) begin
                  addr_next  = npc;
                  state_next = FETCH;
               end else begin
                  state_next = DRAIN;
               end
            end else if (imem_ack) begin
               finstr_next = imem_rdata;
               fpc_next    = addr_reg;
               state_next  = VALID;
            end
         end
         VALID: begin
            // With no redirect the mux selects pc+4, so accept and redirect share a path.
            if (redirect_valid || decode_ready) begin
               pc_next    = npc;
               addr_next  = npc;
               state_next = FETCH;
            end
         end
         DRAIN: begin
            if (redirect_valid) begin
               pc_next = npc;
            end
            if (imem_ack) begin
               addr_next  = redirect_valid ? npc : pc_reg;
               state_next = FETCH;
            end
         end
         default: state_next = START;
      endcase
   end

   assign imem_req    = (state_reg == FETCH) || (state_reg == DRAIN);
   assign imem_addr   = addr_reg;
   assign fetch_valid = (state_reg == VALID);
   assign fetch_pc    = fpc_reg;
   assign fetch_instr = finstr_reg;

endmodule

// File: tb/tb_fetch_unit_v1.sv
// Scoreboard bench for fetch_unit_v1: directed sequences push expected requests
// and accepted instructions; negedge monitors pop and compare.
module tb_fetch_unit_v1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_ack = 1'b0;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;
   logic        decode_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [1:0]  redirect_sel = 2'b00;
   logic [31:0] branch_target = '0;
   logic [31:0] jump_target = '0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_exp_t;

   logic [31:0] exp_addr_q[$];
   fetch_exp_t  exp_fetch_q[$];
   int          errors = 0;
   int          checks = 0;

   fetch_unit_v1 #(
      .width        (32),
      .reset_vector (32'h0000_0000),
      .trap_vector  (32'h0000_0100)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_ack       (imem_ack),
      .fetch_valid    (fetch_valid),
      .fetch_pc       (fetch_pc),
      .fetch_instr    (fetch_instr),
      .decode_ready   (decode_ready),
      .redirect_valid (redirect_valid),
      .redirect_sel   (redirect_sel),
      .branch_target  (branch_target),
      .jump_target    (jump_target)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [31:0] a);
      return a ^ 32'hDEAD_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Acks the current request; deliver=1 means the word must reach decode.
   task automatic do_ack(input logic [31:0] addr, input bit deliver);
      fetch_exp_t e;
      for (int i = 0; i < 20 && !imem_req; i++) cyc();
      chk("req_before_ack", {31'd0, imem_req}, 32'd1);
      exp_addr_q.push_back(addr);
      if (deliver) begin
         e.pc    = addr;
         e.instr = mk(addr);
         exp_fetch_q.push_back(e);
      end
      imem_ack   = 1'b1;
      imem_rdata = mk(addr);
      cyc();
      imem_ack   = 1'b0;
      imem_rdata = '0;
   endtask

   always @(negedge clk) begin
      if (!rst && imem_req && imem_ack) begin
         if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_addr: unexpected request at %h, none required", imem_addr);
         end else begin
            chk("req_addr", imem_addr, exp_addr_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && fetch_valid && decode_ready && !redirect_valid) begin
         if (exp_fetch_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fetch_out: unexpected instr pc=%h instr=%h, none required", fetch_pc, fetch_instr);
         end else begin
            fetch_exp_t e;
            e = exp_fetch_q.pop_front();
            chk("fetch_pc", fetch_pc, e.pc);
            chk("fetch_instr", fetch_instr, e.instr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, required finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      cyc();
      cyc();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_fpc", fetch_pc, 32'h0);
      chk("rst_finstr", fetch_instr, 32'h0);
      rst = 1'b0;
      cyc();
      chk("first_req", {31'd0, imem_req}, 32'd1);

      // Sequential fetch 0x0, 0x4 (stalled), 0x8
      decode_ready = 1'b1;
      do_ack(32'h0, 1);
      cyc();
      decode_ready = 1'b0;
      do_ack(32'h4, 1);
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", {31'd0, fetch_valid}, 32'd1);
         chk("stall_pc", fetch_pc, 32'h4);
         chk("stall_instr", fetch_instr, mk(32'h4));
         chk("stall_noreq", {31'd0, imem_req}, 32'd0);
         cyc();
      end
      decode_ready = 1'b1;
      cyc();
      chk("post_accept_addr", imem_addr, 32'h8);
      do_ack(32'h8, 1);
      cyc();

      // Branch redirect in FETCH without ack, late ack drains stale data
      redirect_valid = 1'b1;
      redirect_sel   = 2'b01;
      branch_target  = 32'h203;
      cyc();
      redirect_valid = 1'b0;
      cyc();
      chk("drain_req", {31'd0, imem_req}, 32'd1);
      chk("drain_addr_held", imem_addr, 32'hC);
      chk("drain_valid", {31'd0, fetch_valid}, 32'd0);
      do_ack(32'hC, 0);
      chk("after_drain_valid", {31'd0, fetch_valid}, 32'd0);
      chk("after_drain_addr", imem_addr, 32'h200);
      do_ack(32'h200, 1);
      cyc();

      // Trap redirect simultaneous with decode_ready in VALID
      decode_ready = 1'b0;
      do_ack(32'h204, 0);
      chk("trap_pre_valid", {31'd0, fetch_valid}, 32'd1);
      decode_ready   = 1'b1;
      redirect_valid = 1'b1;
      redirect_sel   = 2'b11;
      cyc();
      redirect_valid = 1'b0;
      chk("trap_valid_drop", {31'd0, fetch_valid}, 32'd0);
      chk("trap_addr", imem_addr, 32'h100);
      do_ack(32'h100, 1);
      cyc();

      // Jump redirect with ack in FETCH, then wrap from 0xFFFF_FFFC
      redirect_valid = 1'b1;
      redirect_sel   = 2'b10;
      jump_target    = 32'hFFFF_FFFE;
      do_ack(32'h104, 0);
      redirect_valid = 1'b0;
      chk("jump_addr", imem_addr, 32'hFFFF_FFFC);
      do_ack(32'hFFFF_FFFC, 1);
      cyc();
      chk("wrap_addr", imem_addr, 32'h0);

      // Reset while draining
      redirect_valid = 1'b1;
      redirect_sel   = 2'b01;
      branch_target  = 32'h300;
      cyc();
      redirect_valid = 1'b0;
      cyc();
      chk("pre_rst_drain_req", {31'd0, imem_req}, 32'd1);
      rst = 1'b1;
      cyc();
      chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
      chk("mid_rst_valid", {31'd0, fetch_valid}, 32'd0);
      rst = 1'b0;
      cyc();
      do_ack(32'h0, 1);
      cyc();
      cyc();

      chk("addr_q_empty", exp_addr_q.size(), 32'd0);
      chk("fetch_q_empty", exp_fetch_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
